// File: rtl/dijkstra_relax_arbiter.sv
// Round-robin arbiter that serialises Dijkstra edge relaxations onto one shared
// check-step unit and reports whether the candidate distance improves the neighbour.
module dijkstra_relax_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*32-1:0]      req_dist,
    input  logic [NUM_REQ*32-1:0]      req_weight,
    input  logic [NUM_REQ*32-1:0]      req_old_dist,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [31:0]                rsp_dist,
    output logic                       rsp_update,
    output logic                       rsp_err,
    output logic [31:0]                cs_dataa,
    output logic [31:0]                cs_datab,
    output logic                       cs_start,
    output logic                       cs_clk_en,
    output logic                       cs_reset,
    input  logic                       cs_done,
    input  logic [31:0]                cs_result
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        dataa_q, dataa_d;
    logic [31:0]        datab_q, datab_d;
    logic [31:0]        old_q, old_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cs_start_q, cs_start_d;
    logic               cs_reset_q, cs_reset_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_dist_q, rsp_dist_d;
    logic               rsp_update_q, rsp_update_d;
    logic               rsp_err_q, rsp_err_d;

    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;
    logic [ID_W:0]      idx_sum;

    // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
                idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
            end
            if (!sel_found && req[idx_sum[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = idx_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        dataa_d      = dataa_q;
        datab_d      = datab_q;
        old_d        = old_q;
        cnt_d        = cnt_q;
        cs_start_d   = 1'b0;
        cs_reset_d   = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_dist_d   = rsp_dist_q;
        rsp_update_d = rsp_update_q;
        rsp_err_d    = rsp_err_q;
        gnt          = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    gnt        = reset_n ? (NUM_REQ'(1) << sel_idx) : '0;
                    id_d       = sel_idx;
                    dataa_d    = req_dist[32*sel_idx +: 32];
                    datab_d    = req_weight[32*sel_idx +: 32];
                    old_d      = req_old_dist[32*sel_idx +: 32];
                    cs_start_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the last allowed cycle still wins over the abort.
                if (cs_done) begin
                    rsp_dist_d   = cs_result;
                    rsp_err_d    = 1'b0;
                    rsp_update_d = !old_q[31] && (cs_result[30:23] != 8'hFF)
                                   && (cs_result[30:0] < old_q[30:0]);
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_dist_d   = POS_INF;
                    rsp_err_d    = 1'b1;
                    rsp_update_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    cs_reset_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            dataa_q      <= '0;
            datab_q      <= '0;
            old_q        <= '0;
            cnt_q        <= '0;
            cs_start_q   <= 1'b0;
            cs_reset_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dist_q   <= '0;
            rsp_update_q <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            dataa_q      <= dataa_d;
            datab_q      <= datab_d;
            old_q        <= old_d;
            cnt_q        <= cnt_d;
            cs_start_q   <= cs_start_d;
            cs_reset_q   <= cs_reset_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dist_q   <= rsp_dist_d;
            rsp_update_q <= rsp_update_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_dist   = rsp_dist_q;
    assign rsp_update = rsp_update_q;
    assign rsp_err    = rsp_err_q;
    assign cs_dataa   = dataa_q;
    assign cs_datab   = datab_q;
    assign cs_start   = cs_start_q;
    assign cs_clk_en  = 1'b1;
    assign cs_reset   = !reset_n || cs_reset_q;

endmodule
